// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the ALU issue unit.
// The optional EXEC timeout in alu_issue_unit is enabled with ALU_TIMEOUT_EN.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned FLAGS_W = 4;

  localparam logic [OP_W-1:0] OP_PASS_A = 5'd0;
  localparam logic [OP_W-1:0] OP_AND    = 5'd1;
  localparam logic [OP_W-1:0] OP_OR     = 5'd2;
  localparam logic [OP_W-1:0] OP_XOR    = 5'd3;
  localparam logic [OP_W-1:0] OP_NOT    = 5'd4;
  localparam logic [OP_W-1:0] OP_SHL    = 5'd5;
  localparam logic [OP_W-1:0] OP_SHR    = 5'd6;
  localparam logic [OP_W-1:0] OP_SRA    = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL    = 5'd8;
  localparam logic [OP_W-1:0] OP_ROR    = 5'd9;
  localparam logic [OP_W-1:0] OP_PASS_B = 5'd10;
  localparam logic [OP_W-1:0] OP_ADD    = 5'd11;
  localparam logic [OP_W-1:0] OP_ADDC   = 5'd12;
  localparam logic [OP_W-1:0] OP_INC    = 5'd13;
  localparam logic [OP_W-1:0] OP_SUB    = 5'd14;
  localparam logic [OP_W-1:0] OP_DEC    = 5'd15;
  localparam logic [OP_W-1:0] OP_NEG    = 5'd16;
  localparam logic [OP_W-1:0] OP_MUL    = 5'd17;
  localparam logic [OP_W-1:0] OP_SLT    = 5'd18;

  localparam logic [OP_W-1:0] OPCODE_MAX = OP_SLT;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Arithmetic opcodes load the full NZCV set; all others only N and Z.
  function automatic logic op_sets_cv(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_NEG);
  endfunction

endpackage

// File: rtl/issue_regfile.sv
// Operand register array: two enable-latched read ports, one combinational
// debug port, and two write ports where the priority port wins on conflict.
module issue_regfile
  import alu_pkg::*;
#(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data_c,
  input  logic              wp_en,
  input  logic [ADDR_W-1:0] wp_addr,
  input  logic [DATA_W-1:0] wp_data,
  input  logic              wl_en,
  input  logic [ADDR_W-1:0] wl_addr,
  input  logic [DATA_W-1:0] wl_data
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Reads sample pre-edge contents, so a same-edge write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      ra_data <= '0;
      rb_data <= '0;
    end else begin
      if (rd_en) begin
        ra_data <= regs_q[ra_addr];
        rb_data <= regs_q[rb_addr];
      end
      if (wl_en) regs_q[wl_addr] <= wl_data;
      if (wp_en) regs_q[wp_addr] <= wp_data;
    end
  end

  assign dbg_data_c = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Single-issue sequencer that reads operands, drives an external ALU and
// writes the result back. Define ALU_TIMEOUT_EN to bound the EXEC wait.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int unsigned NREGS          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Instr_valid,
  output logic                     Instr_ready,
  input  logic [4:0]               Instr_opcode,
  input  logic [$clog2(NREGS)-1:0] Instr_rd,
  input  logic [$clog2(NREGS)-1:0] Instr_ra,
  input  logic [$clog2(NREGS)-1:0] Instr_rb,
  input  logic                     Load_en,
  input  logic [$clog2(NREGS)-1:0] Load_addr,
  input  logic [31:0]              Load_data,
  input  logic [$clog2(NREGS)-1:0] Rd_addr,
  output logic [31:0]              Rd_data,
  output logic [4:0]               Alu_selection,
  output logic                     Alu_enable,
  output logic [31:0]              Alu_data_A,
  output logic [31:0]              Alu_data_B,
  input  logic [31:0]              Alu_data_out,
  input  logic                     Alu_signal,
  input  logic                     Alu_overflow,
  input  logic                     Alu_carry_out,
  input  logic                     Alu_zero,
  input  logic                     Alu_ready,
  output logic [3:0]               Flags,
  output logic                     Done,
  output logic                     Illegal,
  output logic                     Error
);

  localparam int unsigned ADDR_W = $clog2(NREGS);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("alu_issue_unit: TIMEOUT_CYCLES must be at least 1");
  end

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, alu_sel_q;
  logic [ADDR_W-1:0]   rd_q, ra_q, rb_q;
  logic                bad_op_q;
  logic [DATA_W-1:0]   result_q;
  flags_t              alu_flags_q;
  logic [FLAGS_W-1:0]  flags_q;
  logic                instr_ready_q, alu_en_q, done_q, illegal_q;
  logic                accept_c, rd_en_c, capture_c, wb_we_c, tmo_hit_c;
  logic                timeout_q;

  assign accept_c = Instr_valid && instr_ready_q;
  assign wb_we_c  = (state_q == ST_WB) && !bad_op_q && !timeout_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rd_en_c   = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: if (accept_c) state_d = ST_READ;
      ST_READ: begin
        rd_en_c = !bad_op_q;
        state_d = bad_op_q ? ST_WB : ST_EXEC;
      end
      ST_EXEC: begin
        if (Alu_ready) begin
          capture_c = 1'b1;
          state_d   = ST_WB;
        end else if (tmo_hit_c) begin
          state_d = ST_WB;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake/status outputs are registered from the next state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      instr_ready_q <= 1'b1;
      alu_en_q      <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      op_q          <= '0;
      alu_sel_q     <= '0;
      rd_q          <= '0;
      ra_q          <= '0;
      rb_q          <= '0;
      bad_op_q      <= 1'b0;
      result_q      <= '0;
      alu_flags_q   <= '0;
      flags_q       <= '0;
    end else begin
      instr_ready_q <= (state_d == ST_IDLE);
      alu_en_q      <= (state_d == ST_EXEC);
      done_q        <= (state_d == ST_WB);
      illegal_q     <= (state_d == ST_WB) && bad_op_q;
      if (accept_c) begin
        op_q     <= Instr_opcode;
        rd_q     <= Instr_rd;
        ra_q     <= Instr_ra;
        rb_q     <= Instr_rb;
        bad_op_q <= (Instr_opcode > OPCODE_MAX);
      end
      if (rd_en_c) alu_sel_q <= op_q;
      if (capture_c) begin
        result_q    <= Alu_data_out;
        alu_flags_q <= '{n: Alu_signal, z: Alu_zero, c: Alu_carry_out, v: Alu_overflow};
      end
      if (wb_we_c) begin
        flags_q[FLAG_N] <= alu_flags_q.n;
        flags_q[FLAG_Z] <= alu_flags_q.z;
        if (op_sets_cv(op_q)) begin
          flags_q[FLAG_C] <= alu_flags_q.c;
          flags_q[FLAG_V] <= alu_flags_q.v;
        end
      end
    end
  end

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             error_q;

  // Counter holds the number of EXEC cycles already spent on this instruction.
  assign tmo_hit_c = (state_q == ST_EXEC) && !Alu_ready &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == ST_EXEC) ? tmo_cnt_q + CNT_W'(1) : '0;
      error_q   <= tmo_hit_c;
      if (accept_c)       timeout_q <= 1'b0;
      else if (tmo_hit_c) timeout_q <= 1'b1;
    end
  end

  assign Error = error_q;
`else
  assign tmo_hit_c = 1'b0;
  assign timeout_q = 1'b0;
  assign Error     = 1'b0;
`endif

  issue_regfile #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .rd_en      (rd_en_c),
    .ra_addr    (ra_q),
    .rb_addr    (rb_q),
    .ra_data    (Alu_data_A),
    .rb_data    (Alu_data_B),
    .dbg_addr   (Rd_addr),
    .dbg_data_c (Rd_data),
    .wp_en      (wb_we_c),
    .wp_addr    (rd_q),
    .wp_data    (result_q),
    .wl_en      (Load_en),
    .wl_addr    (Load_addr),
    .wl_data    (Load_data)
  );

  assign Instr_ready   = instr_ready_q;
  assign Alu_enable    = alu_en_q;
  assign Alu_selection = alu_sel_q;
  assign Flags         = flags_q;
  assign Done          = done_q;
  assign Illegal       = illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a small behavioural ALU attached.
module tb_alu_issue_unit;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Instr_valid;
  logic        Instr_ready;
  logic [4:0]  Instr_opcode;
  logic [3:0]  Instr_rd, Instr_ra, Instr_rb;
  logic        Load_en;
  logic [3:0]  Load_addr;
  logic [31:0] Load_data;
  logic [3:0]  Rd_addr;
  logic [31:0] Rd_data;
  logic [4:0]  Alu_selection;
  logic        Alu_enable;
  logic [31:0] Alu_data_A, Alu_data_B, Alu_data_out;
  logic        Alu_signal, Alu_overflow, Alu_carry_out, Alu_zero, Alu_ready;
  logic [3:0]  Flags;
  logic        Done, Illegal, Error;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic        alu_auto = 1'b1;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  alu_issue_unit #(.NREGS(16), .TIMEOUT_CYCLES(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Instr_valid(Instr_valid), .Instr_ready(Instr_ready),
    .Instr_opcode(Instr_opcode), .Instr_rd(Instr_rd), .Instr_ra(Instr_ra), .Instr_rb(Instr_rb),
    .Load_en(Load_en), .Load_addr(Load_addr), .Load_data(Load_data),
    .Rd_addr(Rd_addr), .Rd_data(Rd_data),
    .Alu_selection(Alu_selection), .Alu_enable(Alu_enable),
    .Alu_data_A(Alu_data_A), .Alu_data_B(Alu_data_B), .Alu_data_out(Alu_data_out),
    .Alu_signal(Alu_signal), .Alu_overflow(Alu_overflow), .Alu_carry_out(Alu_carry_out),
    .Alu_zero(Alu_zero), .Alu_ready(Alu_ready),
    .Flags(Flags), .Done(Done), .Illegal(Illegal), .Error(Error)
  );

  // Behavioural ALU: only the operations the scenarios use are modelled.
  logic [31:0] alu_res;
  logic        alu_c, alu_v;
  logic [32:0] sum;
  always_comb begin
    alu_res = Alu_data_A;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum     = '0;
    case (Alu_selection)
      5'd1: alu_res = Alu_data_A & Alu_data_B;
      5'd2: alu_res = Alu_data_A | Alu_data_B;
      5'd3: alu_res = Alu_data_A ^ Alu_data_B;
      5'd11: begin
        sum     = {1'b0, Alu_data_A} + {1'b0, Alu_data_B};
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = (Alu_data_A[31] == Alu_data_B[31]) && (alu_res[31] != Alu_data_A[31]);
      end
      5'd14: begin
        alu_res = Alu_data_A - Alu_data_B;
        alu_c   = (Alu_data_A >= Alu_data_B);
        alu_v   = (Alu_data_A[31] != Alu_data_B[31]) && (alu_res[31] != Alu_data_A[31]);
      end
      default: alu_res = Alu_data_A;
    endcase
  end
  assign Alu_data_out  = alu_res;
  assign Alu_signal    = alu_res[31];
  assign Alu_zero      = (alu_res == 32'd0);
  assign Alu_carry_out = alu_c;
  assign Alu_overflow  = alu_v;
  assign Alu_ready     = alu_auto && Alu_enable;

  typedef struct packed {
    logic [7:0]  lat;
    logic        ill;
    logic        err;
    logic [3:0]  flags;
    logic [31:0] val;
  } res_t;

  typedef struct packed {
    logic [3:0] rd;
    res_t       res;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input logic [3:0] rd, input int lat, input logic ill,
                              input logic err, input logic [3:0] flags, input logic [31:0] val);
    exp_t e;
    e.rd        = rd;
    e.res.lat   = 8'(lat);
    e.res.ill   = ill;
    e.res.err   = err;
    e.res.flags = flags;
    e.res.val   = val;
    return e;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("lat=%0d ill=%b err=%b flags=%b val=%h", r.lat, r.ill, r.err, r.flags, r.val);
  endfunction

  task automatic load_reg(input logic [3:0] a, input logic [31:0] d);
    Load_en = 1'b1; Load_addr = a; Load_data = d;
    @(posedge Clock); #1;
    Load_en = 1'b0;
  endtask

  // Returns #1 after the accept edge, i.e. in cycle 2 of the instruction.
  task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, output int unsigned acc);
    int n;
    n = 0;
    while (!Instr_ready && n < 20) begin @(posedge Clock); #1; n++; end
    Instr_valid = 1'b1; Instr_opcode = op; Instr_rd = rd; Instr_ra = ra; Instr_rb = rb;
    @(posedge Clock); #1;
    acc = cyc;
    Instr_valid = 1'b0;
  endtask

  // Waits for Done (bounded), pops the scoreboard and reads back rd and Flags.
  task automatic retire(input int start, output logic ok, output res_t got, output exp_t e);
    int lat;
    lat = start;
    while (!Done && lat < 40) begin @(posedge Clock); #1; lat++; end
    ok      = Done;
    got.lat = 8'(lat);
    got.ill = Illegal;
    got.err = Error;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = '0;
    @(posedge Clock); #1;
    Load_en = 1'b0;
    Rd_addr = e.rd;
    #1;
    got.val   = Rd_data;
    got.flags = Flags;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Instr_valid = 1'b0; Instr_opcode = '0; Instr_rd = '0; Instr_ra = '0;
    Instr_rb = '0; Load_en = 1'b0; Load_addr = '0; Load_data = '0; Rd_addr = '0;
    repeat (2) @(posedge Clock);
    #1;
    n_checks++;
    if ({Instr_ready, Done, Illegal, Error, Alu_enable, Flags} !== 9'b1_0000_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 100000000",
               {Instr_ready, Done, Illegal, Error, Alu_enable, Flags});
    end
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if ({Instr_ready, Alu_data_A, Alu_data_B} !== {1'b1, 64'd0}) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b A=%h B=%h required 1/0/0", Instr_ready, Alu_data_A, Alu_data_B);
    end
    for (int i = 0; i < 16; i += 15) begin
      Rd_addr = 4'(i); #1;
      n_checks++;
      if (Rd_data !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h required 0", i, Rd_data);
      end
    end
  endtask

  task automatic test_add();
    int unsigned acc; logic ok; res_t got; exp_t e;
    load_reg(4'd1, 32'd5);
    load_reg(4'd2, 32'd3);
    exp_q.push_back(mk(4'd3, 4, 1'b0, 1'b0, 4'b0000, 32'd8));
    issue(5'd11, 4'd3, 4'd1, 4'd2, acc);
    retire(2, ok, got, e);
    n_checks++;
    if (!ok || got !== e.res) begin
      n_fail++;
      $display("FAIL add_basic: got %s, required %s", fmt(got), fmt(e.res));
    end
  endtask

  task automatic test_overflow();
    int unsigned acc; logic ok; res_t got; exp_t e;
    load_reg(4'd1, 32'h7FFF_FFFF);
    load_reg(4'd2, 32'd1);
    exp_q.push_back(mk(4'd4, 4, 1'b0, 1'b0, 4'b1001, 32'h8000_0000));
    issue(5'd11, 4'd4, 4'd1, 4'd2, acc);
    retire(2, ok, got, e);
    n_checks++;
    if (!ok || got !== e.res) begin
      n_fail++;
      $display("FAIL add_overflow: got %s, required %s", fmt(got), fmt(e.res));
    end
  endtask

  task automatic test_back_to_back();
    int unsigned a1, a2; logic ok; res_t got; exp_t e;
    load_reg(4'd1, 32'd5);
    load_reg(4'd2, 32'd5);
    exp_q.push_back(mk(4'd5, 4, 1'b0, 1'b0, 4'b0110, 32'd0));
    issue(5'd14, 4'd5, 4'd1, 4'd2, a1);
    retire(2, ok, got, e);
    n_checks++;
    if (!ok || got !== e.res) begin
      n_fail++;
      $display("FAIL sub_zero: got %s, required %s", fmt(got), fmt(e.res));
    end
    // AND only loads N,Z: C=1 from the subtract must survive.
    exp_q.push_back(mk(4'd5, 4, 1'b0, 1'b0, 4'b0110, 32'd0));
    issue(5'd1, 4'd5, 4'd5, 4'd1, a2);
    retire(2, ok, got, e);
    n_checks++;
    if (!ok || got !== e.res) begin
      n_fail++;
      $display("FAIL and_hold_cv: got %s, required %s", fmt(got), fmt(e.res));
    end
    n_checks++;
    if (a2 - a1 !== 4) begin
      n_fail++;
      $display("FAIL accept_interval: got %0d cycles required 4", a2 - a1);
    end
  endtask

  task automatic test_illegal();
    int unsigned acc; logic ok; res_t got; exp_t e;
    exp_q.push_back(mk(4'd3, 3, 1'b1, 1'b0, 4'b0110, 32'd8));
    issue(5'd25, 4'd3, 4'd1, 4'd2, acc);
    retire(2, ok, got, e);
    n_checks++;
    if (!ok || got !== e.res) begin
      n_fail++;
      $display("FAIL illegal_op: got %s, required %s", fmt(got), fmt(e.res));
    end
  endtask

`ifdef ALU_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned acc; logic ok; res_t got; exp_t e;
    alu_auto = 1'b0;
    exp_q.push_back(mk(4'd3, 11, 1'b0, 1'b1, 4'b0110, 32'd8));
    issue(5'd11, 4'd3, 4'd1, 4'd2, acc);
    retire(2, ok, got, e);
    alu_auto = 1'b1;
    n_checks++;
    if (!ok || got !== e.res) begin
      n_fail++;
      $display("FAIL alu_timeout: got %s, required %s", fmt(got), fmt(e.res));
    end
  endtask
`endif

  task automatic test_load_hazards();
    int unsigned acc; logic ok; res_t got; exp_t e;
    load_reg(4'd1, 32'd10);
    load_reg(4'd2, 32'd20);
    // Load to ra during READ: operand must be the old value.
    exp_q.push_back(mk(4'd7, 4, 1'b0, 1'b0, 4'b0000, 32'd30));
    issue(5'd11, 4'd7, 4'd1, 4'd2, acc);
    Load_en = 1'b1; Load_addr = 4'd1; Load_data = 32'd100;
    @(posedge Clock); #1;
    Load_en = 1'b0;
    retire(3, ok, got, e);
    n_checks++;
    if (!ok || got !== e.res) begin
      n_fail++;
      $display("FAIL load_in_read: got %s, required %s", fmt(got), fmt(e.res));
    end
    Rd_addr = 4'd1; #1;
    n_checks++;
    if (Rd_data !== 32'd100) begin
      n_fail++;
      $display("FAIL load_in_read_reg: got %h required 00000064", Rd_data);
    end
    // Load to rd in the WB cycle: writeback must win.
    exp_q.push_back(mk(4'd8, 4, 1'b0, 1'b0, 4'b0000, 32'd120));
    issue(5'd11, 4'd8, 4'd1, 4'd2, acc);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Load_en = 1'b1; Load_addr = 4'd8; Load_data = 32'hDEAD_BEEF;
    retire(4, ok, got, e);
    n_checks++;
    if (!ok || got !== e.res) begin
      n_fail++;
      $display("FAIL wb_beats_load: got %s, required %s", fmt(got), fmt(e.res));
    end
    // ra == rb == rd
    load_reg(4'd9, 32'd7);
    exp_q.push_back(mk(4'd9, 4, 1'b0, 1'b0, 4'b0000, 32'd14));
    issue(5'd11, 4'd9, 4'd9, 4'd9, acc);
    retire(2, ok, got, e);
    n_checks++;
    if (!ok || got !== e.res) begin
      n_fail++;
      $display("FAIL same_regs: got %s, required %s", fmt(got), fmt(e.res));
    end
    load_reg(4'd10, 32'h0000_A5A5);
    Rd_addr = 4'd10; #1;
    n_checks++;
    if (Rd_data !== 32'h0000_A5A5) begin
      n_fail++;
      $display("FAIL debug_read: got %h required 0000a5a5", Rd_data);
    end
  endtask

  task automatic test_reset_mid_exec();
    int unsigned acc; logic saw;
    alu_auto = 1'b0;
    issue(5'd11, 4'd6, 4'd1, 4'd2, acc);
    @(posedge Clock); #1;
    n_checks++;
    if ({Alu_enable, Alu_selection, Alu_data_A, Alu_data_B} !== {1'b1, 5'd11, 32'd100, 32'd20}) begin
      n_fail++;
      $display("FAIL exec_drive: en=%b sel=%0d A=%h B=%h required 1/11/00000064/00000014",
               Alu_enable, Alu_selection, Alu_data_A, Alu_data_B);
    end
    Reset_n = 1'b0; #1;
    n_checks++;
    if ({Instr_ready, Alu_enable, Done} !== 3'b100) begin
      n_fail++;
      $display("FAIL async_reset: ready/en/done=%b required 100", {Instr_ready, Alu_enable, Done});
    end
    @(posedge Clock); #1;
    Reset_n  = 1'b1;
    alu_auto = 1'b1;
    saw = 1'b0;
    repeat (6) begin @(posedge Clock); #1; saw |= Done; end
    n_checks++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: Done seen=%b required 0", saw);
    end
    Rd_addr = 4'd6; #1;
    n_checks++;
    if ({Rd_data, Flags, Instr_ready} !== {32'd0, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_discard: r6=%h flags=%b ready=%b required 0/0000/1", Rd_data, Flags, Instr_ready);
    end
  endtask

  task automatic test_recovery();
    int unsigned acc; logic ok; res_t got; exp_t e;
    load_reg(4'd1, 32'd2);
    load_reg(4'd2, 32'd3);
    exp_q.push_back(mk(4'd6, 4, 1'b0, 1'b0, 4'b0000, 32'd5));
    issue(5'd11, 4'd6, 4'd1, 4'd2, acc);
    retire(2, ok, got, e);
    n_checks++;
    if (!ok || got !== e.res) begin
      n_fail++;
      $display("FAIL post_reset_add: got %s, required %s", fmt(got), fmt(e.res));
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_back_to_back();
    test_illegal();
`ifdef ALU_TIMEOUT_EN
    test_timeout();
`endif
    test_load_hazards();
    test_reset_mid_exec();
    test_recovery();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
